fft_frame_rd_buffer: RTL and testbench
======================================

// Module: fft_frame_rd_buffer
// PURPOSE
//   Output-side frame buffer between the 128-point FFT core and the AXI read-data path.
//   Captures one full FFT output frame ({real,imag} per sample) into on-chip storage.
//   Returns the frame to the AXI slave's R channel as one or more ID-tagged bursts.
//   Gives the FFT free-running output a proper AR/R valid/ready handshake.
// PARAMETERS
//   DEPTH     128  samples per FFT frame; must be a power of two
//   AW        7    pointer width, log2(DEPTH)
//   WIDTH_DA  32   data width: real in [31:16], imag in [15:0]
//   WIDTH_ID  15   AXI transaction ID width
// PORTS
//   clk         in   1         system clock; all logic on rising edge
//   reset       in   1         synchronous, active-high reset
//   fft_valid   in   1         FFT output sample valid this cycle
//   fft_real    in   16        FFT output, real part
//   fft_imag    in   16        FFT output, imaginary part
//   frame_rdy   out  1         complete frame held, readable
//   overflow    out  1         sticky: a sample arrived while the buffer was not in FILL
//   ar_valid    in   1         read request valid
//   ar_ready    out  1         read request accepted
//   ar_id       in   WIDTH_ID  read request ID
//   ar_len      in   8         beats minus one (AXI LEN)
//   r_valid     out  1         read data valid
//   r_ready     in   1         read data accepted
//   r_data      out  WIDTH_DA  read data
//   r_id        out  WIDTH_ID  ID of the current burst
//   r_last      out  1         final beat of the burst
//   r_resp      out  2         2'b00 OKAY; 2'b10 SLVERR on beats past the frame end
// BEHAVIOUR
//   Reset state: FILL. wr_ptr=0, rd_ptr=0, beat=0.
//     All outputs reset to 0: frame_rdy, overflow, ar_ready, r_valid, r_last, r_data, r_id, r_resp.
//   States and transitions:
//     FILL  -> READY  on the fft_valid that writes address DEPTH-1.
//     READY -> BURST  on the AR handshake (ar_valid && ar_ready).
//     BURST -> READY  on the last-beat handshake, frame not fully read.
//     BURST -> FILL   on the last-beat handshake, frame fully read.
//   FILL:
//     Each fft_valid writes {fft_real,fft_imag} to mem[wr_ptr] and increments wr_ptr.
//     No backpressure toward the FFT.
//   READY:
//     frame_rdy=1, ar_ready=1 (combinational from state).
//     On AR handshake: latch ar_id -> r_id, ar_len -> len; beat=0.
//   BURST:
//     ar_ready=0. r_valid asserts the cycle after the AR handshake (read latency 1).
//     Beat data is mem[rd_ptr], registered.
//     r_data, r_id, r_last and r_resp stay stable while r_valid && !r_ready.
//     On each r_valid && r_ready: beat++; rd_ptr++ while rd_ptr < DEPTH; next word is loaded the same edge.
//     Back-to-back beats run at full rate when r_ready is held high.
//     r_last=1 exactly on beat==len.
//     Beats issued after all DEPTH words are consumed: r_data=0, r_resp=2'b10.
//   Last-beat handshake:
//     r_valid=0 next cycle.
//     If all DEPTH words have been read: frame_rdy=0, wr_ptr=rd_ptr=0, go to FILL.
//     Otherwise go to READY; rd_ptr continues across bursts.
//   Overflow:
//     fft_valid in READY or BURST drops the sample and sets overflow; only reset clears it.
//     fft_valid on the same edge as the final-read handshake is dropped (still BURST).
//     The first sample written is the one in the following cycle.
//   Reset mid-operation: any in-flight burst and frame are discarded; r_valid=0 next cycle.
//   Memory contents are not reset; they are unobservable until rewritten.
// TESTING
//   1. Reset; 128 fft_valid with real=i, imag=~i.
//      -> frame_rdy=1 after the 128th; ar_ready=1.
//   2. AR id=0x1A, len=127, r_ready=1.
//      -> 128 beats on consecutive cycles: r_data={i,~i}, r_id=0x1A, r_last only on beat 127.
//      -> Then FILL, frame_rdy=0.
//   3. Two ARs, len=63 then len=63, r_ready toggled 1/0.
//      -> Words 0-63 then 64-127; data stable while stalled.
//      -> ar_ready=0 during each burst.
//   4. AR len=131 on a full frame.
//      -> Beats 0-127 OKAY; beats 128-131: r_data=0, r_resp=2'b10.
//      -> r_last on beat 131; then FILL.
//   5. fft_valid during READY and on the final-read edge.
//      -> overflow=1, samples dropped; the next frame's first sample lands at address 0.
//   6. reset asserted at beat 40 of a burst.
//      -> r_valid=0, frame_rdy=0, overflow=0 next cycle; a fresh 128-sample fill works.

Source files
------------

// File: rtl/fft_frame_rd_buffer_if.sv
// FFT sample input plus AXI AR/R read-channel bundle for the FFT frame read buffer.
// The slave modport is the buffer; the master modport is the FFT core and AXI slave side.
interface fft_frame_rd_buffer_if #(
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_ID = 15
);
  logic                fft_valid;
  logic [15:0]         fft_real;
  logic [15:0]         fft_imag;
  logic                frame_rdy;
  logic                overflow;
  logic                ar_valid;
  logic                ar_ready;
  logic [WIDTH_ID-1:0] ar_id;
  logic [7:0]          ar_len;
  logic                r_valid;
  logic                r_ready;
  logic [WIDTH_DA-1:0] r_data;
  logic [WIDTH_ID-1:0] r_id;
  logic                r_last;
  logic [1:0]          r_resp;

  modport master (
    output fft_valid, fft_real, fft_imag, ar_valid, ar_id, ar_len, r_ready,
    input  frame_rdy, overflow, ar_ready, r_valid, r_data, r_id, r_last, r_resp
  );

  modport slave (
    input  fft_valid, fft_real, fft_imag, ar_valid, ar_id, ar_len, r_ready,
    output frame_rdy, overflow, ar_ready, r_valid, r_data, r_id, r_last, r_resp
  );
endinterface

// File: rtl/fft_frame_rd_buffer.sv
// Captures one FFT output frame, then replays it as ID-tagged AXI read bursts.
// Reads continue across bursts; beats past the frame end return zero data with SLVERR.
module fft_frame_rd_buffer #(
  parameter int DEPTH    = 128,
  parameter int AW       = 7,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_ID = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_rd_buffer_if.slave  bus
);
  typedef enum logic [1:0] {S_FILL, S_READY, S_BURST} state_t;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_WR = AW'(DEPTH-1);

  state_t              r_state;
  logic [WIDTH_DA-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [7:0]          r_beat;
  logic [7:0]          r_len;
  logic                r_ovf;
  logic                r_rvalid;
  logic [WIDTH_DA-1:0] r_rdata;
  logic [WIDTH_ID-1:0] r_rid;
  logic                r_rlast;
  logic [1:0]          r_rresp;

  logic                w_wr_en;
  logic                w_r_hs;
  logic                w_last_hs;
  logic [AW:0]         w_rd_nxt;
  logic [AW:0]         w_fetch_ptr;
  logic                w_fetch_ok;
  logic [WIDTH_DA-1:0] w_fetch_data;

  assign w_wr_en      = (r_state == S_FILL) && bus.fft_valid;
  assign w_r_hs       = r_rvalid && bus.r_ready;
  assign w_last_hs    = w_r_hs && (r_beat == r_len);
  // rd_ptr saturates at DEPTH so overrun beats keep reporting SLVERR
  assign w_rd_nxt     = r_rd_ptr + {{AW{1'b0}}, (r_rd_ptr < FULL)};
  assign w_fetch_ptr  = (r_state == S_BURST) ? w_rd_nxt : r_rd_ptr;
  assign w_fetch_ok   = w_fetch_ptr < FULL;
  assign w_fetch_data = w_fetch_ok ? r_mem[w_fetch_ptr[AW-1:0]] : '0;

  assign bus.frame_rdy = (r_state != S_FILL);
  assign bus.ar_ready  = (r_state == S_READY);
  assign bus.overflow  = r_ovf;
  assign bus.r_valid   = r_rvalid;
  assign bus.r_data    = r_rdata;
  assign bus.r_id      = r_rid;
  assign bus.r_last    = r_rlast;
  assign bus.r_resp    = r_rresp;

  // storage is deliberately unreset; stale words are never returned before a refill
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en)
      r_mem[r_wr_ptr] <= {bus.fft_real, bus.fft_imag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_beat   <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
      r_rlast  <= 1'b0;
      r_rresp  <= 2'b00;
    end else begin
      if (bus.fft_valid && r_state != S_FILL)
        r_ovf <= 1'b1;
      case (r_state)
        S_FILL: begin
          if (bus.fft_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_WR)
              r_state <= S_READY;
          end
        end
        S_READY: begin
          if (bus.ar_valid) begin
            r_rid    <= bus.ar_id;
            r_len    <= bus.ar_len;
            r_beat   <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= w_fetch_data;
            r_rresp  <= w_fetch_ok ? 2'b00 : 2'b10;
            r_rlast  <= (bus.ar_len == 8'd0);
            r_state  <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_last_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_beat   <= r_beat + 8'd1;
            if (w_rd_nxt == FULL) begin
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
              r_state  <= S_FILL;
            end else begin
              r_rd_ptr <= w_rd_nxt;
              r_state  <= S_READY;
            end
          end else if (w_r_hs) begin
            r_beat   <= r_beat + 8'd1;
            r_rd_ptr <= w_rd_nxt;
            r_rdata  <= w_fetch_data;
            r_rresp  <= w_fetch_ok ? 2'b00 : 2'b10;
            r_rlast  <= ((r_beat + 8'd1) == r_len);
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_rd_buffer.sv
// Scoreboard bench for fft_frame_rd_buffer: AR issue pushes expected beats from a
// frame model; a negedge monitor checks every presented beat, including stalled ones.
module tb_fft_frame_rd_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_frame_rd_buffer_if #(.WIDTH_DA(32), .WIDTH_ID(15)) bus();

  fft_frame_rd_buffer #(.DEPTH(128), .AW(7), .WIDTH_DA(32), .WIDTH_ID(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [14:0] id;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_got;
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] model_mem [128];
  int          model_rd;
  bit          exp_ovf;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Beats are presented on r_valid; a stalled beat must match the head without popping.
  always @(negedge clk) begin
    if (!reset && bus.r_valid) begin
      mon_got = {bus.r_data, bus.r_id, bus.r_last, bus.r_resp};
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", mon_got);
      end else begin
        chk(bus.r_ready ? "beat" : "stall_hold", 64'(mon_got), 64'(exp_q[0]));
        if (bus.r_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic fill(input bit pattern);
    logic [31:0] d;
    for (int i = 0; i < 128; i++) begin
      while (!pattern && $urandom_range(0, 3) == 0) begin
        bus.fft_valid = 1'b0;
        cyc();
      end
      if (i == 127) chk("frame_rdy_before_last", 64'(bus.frame_rdy), 64'(0));
      d = pattern ? {i[15:0], ~i[15:0]} : $urandom();
      bus.fft_valid = 1'b1;
      bus.fft_real  = d[31:16];
      bus.fft_imag  = d[15:0];
      model_mem[i]  = d;
      cyc();
    end
    bus.fft_valid = 1'b0;
    model_rd = 0;
    chk("frame_rdy_full", 64'(bus.frame_rdy), 64'(1));
    chk("ar_ready_full", 64'(bus.ar_ready), 64'(1));
  endtask

  // rmode: 0 = r_ready held high, 1 = toggled, 2 = random
  task automatic burst(input logic [14:0] id, input logic [7:0] len, input int rmode,
                       input int abort_at, input bit junk_last);
    int    n;
    int    guard;
    beat_t b;
    guard = 0;
    while (!bus.ar_ready && guard < 50) begin
      cyc();
      guard++;
    end
    if (!bus.ar_ready) begin
      vectors++;
      errors++;
      $display("FAIL ar_wait: ar_ready stayed %b, required 1", bus.ar_ready);
      return;
    end
    for (int k = 0; k <= int'(len); k++) begin
      b.id   = id;
      b.last = (k == int'(len));
      if (model_rd < 128) begin
        b.data = model_mem[model_rd];
        b.resp = 2'b00;
        model_rd++;
      end else begin
        b.data = 32'h0;
        b.resp = 2'b10;
      end
      exp_q.push_back(b);
    end
    n = int'(len) + 1;
    bus.ar_valid = 1'b1;
    bus.ar_id    = id;
    bus.ar_len   = len;
    cyc();
    bus.ar_valid = 1'b0;
    chk("ar_ready_in_burst", 64'(bus.ar_ready), 64'(0));
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      if (abort_at >= 0 && (n - exp_q.size()) == abort_at) return;
      case (rmode)
        0:       bus.r_ready = 1'b1;
        1:       bus.r_ready = ~bus.r_ready;
        default: bus.r_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk_last && exp_q.size() == 1 && bus.r_valid && bus.r_ready) begin
        bus.fft_valid = 1'b1;
        bus.fft_real  = 16'hDEAD;
        bus.fft_imag  = 16'hBEEF;
        exp_ovf       = 1'b1;
      end
      cyc();
      bus.fft_valid = 1'b0;
      guard++;
    end
    bus.r_ready = 1'b0;
    if (guard >= 3000) begin
      vectors++;
      errors++;
      $display("FAIL burst_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    chk("r_valid_after_last", 64'(bus.r_valid), 64'(0));
    chk("frame_rdy_after_burst", 64'(bus.frame_rdy), 64'(model_rd < 128));
    chk("ar_ready_after_burst", 64'(bus.ar_ready), 64'(model_rd < 128));
    chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.fft_valid = 1'b0;
    bus.ar_valid  = 1'b0;
    bus.r_ready   = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset    = 1'b0;
    model_rd = 0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    bus.fft_valid = 1'b0;
    bus.fft_real  = '0;
    bus.fft_imag  = '0;
    bus.ar_valid  = 1'b0;
    bus.ar_id     = '0;
    bus.ar_len    = '0;
    bus.r_ready   = 1'b0;
    do_reset();
    chk("rst_frame_rdy", 64'(bus.frame_rdy), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'(0));
    chk("rst_r_valid", 64'(bus.r_valid), 64'(0));
    chk("rst_r_fields", 64'({bus.r_data, bus.r_id, bus.r_last, bus.r_resp}), 64'(0));

    // full frame, one full-rate burst
    fill(1'b1);
    burst(15'h1A, 8'd127, 0, -1, 1'b0);

    // two half bursts with a stalling reader
    fill(1'b0);
    burst(15'($urandom()), 8'd63, 1, -1, 1'b0);
    burst(15'($urandom()), 8'd63, 1, -1, 1'b0);

    // overrun past the frame end
    fill(1'b0);
    burst(15'($urandom()), 8'd131, 2, -1, 1'b0);

    // samples in READY and on the final-read edge are dropped
    fill(1'b0);
    bus.fft_valid = 1'b1;
    bus.fft_real  = 16'h1234;
    bus.fft_imag  = 16'h5678;
    exp_ovf       = 1'b1;
    cyc();
    bus.fft_valid = 1'b0;
    chk("overflow_in_ready", 64'(bus.overflow), 64'(1));
    burst(15'h7ABC, 8'd127, 0, -1, 1'b1);
    fill(1'b1);
    burst(15'h0042, 8'd127, 2, -1, 1'b0);

    // reset mid-burst
    fill(1'b0);
    burst(15'h0055, 8'd127, 0, 40, 1'b0);
    reset       = 1'b1;
    bus.r_ready = 1'b0;
    exp_q.delete();
    cyc();
    chk("midrst_r_valid", 64'(bus.r_valid), 64'(0));
    chk("midrst_frame_rdy", 64'(bus.frame_rdy), 64'(0));
    chk("midrst_overflow", 64'(bus.overflow), 64'(0));
    reset    = 1'b0;
    exp_ovf  = 1'b0;
    model_rd = 0;
    fill(1'b0);
    burst(15'h0066, 8'd127, 2, -1, 1'b0);

    // random frames split into random-length bursts
    for (int f = 0; f < 3; f++) begin
      fill(1'b0);
      while (model_rd < 128)
        burst(15'($urandom()), 8'($urandom_range(0, 50)), 2, -1, 1'b0);
    end

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
